// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection. Feeds the ALU with SrcA, SrcB and Operation.
// Optional feature macro: ID_EX_FORWARDING_EN
//   defined   : EX/MEM and MEM/WB forwarding muxes, load-use interlock.
//   undefined : no forwarding; general RAW interlock against EX and EX/MEM.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic                     load_use_hazard
);

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [REG_ADDR_W-1:0]    rs1;
    logic [REG_ADDR_W-1:0]    rs2;
    logic [REG_ADDR_W-1:0]    rd;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     alu_src;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     mem_to_reg;
  } stage_t;

  stage_t stage_q, stage_d, id_fields;

  logic                  hazard_raw;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  // Gather the decode-slot fields into one capture word.
  always_comb begin
    id_fields            = '0;
    id_fields.valid      = id_valid;
    id_fields.pc         = id_pc;
    id_fields.rs1_data   = id_rs1_data;
    id_fields.rs2_data   = id_rs2_data;
    id_fields.imm        = id_imm;
    id_fields.rs1        = id_rs1;
    id_fields.rs2        = id_rs2;
    id_fields.rd         = id_rd;
    id_fields.alu_op     = id_alu_op;
    id_fields.alu_src    = id_alu_src;
    id_fields.reg_write  = id_reg_write;
    id_fields.mem_read   = id_mem_read;
    id_fields.mem_write  = id_mem_write;
    id_fields.mem_to_reg = id_mem_to_reg;
  end

`ifdef ID_EX_FORWARDING_EN
  // Load-use: a load in EX whose result the decode slot needs cannot be
  // forwarded in time, so ID must wait one cycle.
  always_comb begin
    hazard_raw = 1'b0;
    if (id_valid && stage_q.valid && stage_q.mem_read &&
        (stage_q.rd != '0) &&
        ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2)))
      hazard_raw = 1'b1;
  end

  // Operand forwarding; MEM/WB is applied first so EX/MEM overrides it
  // as the younger producer.
  always_comb begin
    fwd_a = stage_q.rs1_data;
    fwd_b = stage_q.rs2_data;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == stage_q.rs1))
      fwd_a = memwb_result;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == stage_q.rs1))
      fwd_a = exmem_result;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == stage_q.rs2))
      fwd_b = memwb_result;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == stage_q.rs2))
      fwd_b = exmem_result;
  end
`else
  logic unused_fwd_sources;
  assign unused_fwd_sources = ^{memwb_rd, memwb_reg_write, memwb_result,
                                stage_q.rs1, stage_q.rs2};

  // RAW interlock: without forwarding, ID waits until its producers have
  // left EX and EX/MEM; MEM/WB is covered by the write-before-read file.
  always_comb begin
    hazard_raw = 1'b0;
    if (id_valid) begin
      if ((id_rs1 != '0) &&
          ((stage_q.valid && stage_q.reg_write && (stage_q.rd == id_rs1)) ||
           (exmem_reg_write && (exmem_rd == id_rs1))))
        hazard_raw = 1'b1;
      if ((id_rs2 != '0) &&
          ((stage_q.valid && stage_q.reg_write && (stage_q.rd == id_rs2)) ||
           (exmem_reg_write && (exmem_rd == id_rs2))))
        hazard_raw = 1'b1;
    end
  end

  // Operands come straight from the registered register-file data.
  always_comb begin
    fwd_a = stage_q.rs1_data;
    fwd_b = stage_q.rs2_data;
  end
`endif

  // No stall request is raised while the stage is held in reset.
  assign load_use_hazard = reset & hazard_raw;

  // Next-state selection: flush > stall > hazard bubble > capture.
  always_comb begin
    stage_d = stage_q;
    if (flush)
      stage_d = '0;
    else if (stall)
      stage_d = stage_q;
    else if (load_use_hazard)
      stage_d = '0;
    else
      stage_d = id_fields;
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset)
      stage_q <= '0;
    else
      stage_q <= stage_d;
  end

  // Operand outputs; a bubble drives zero operands.
  always_comb begin
    SrcA          = '0;
    SrcB          = '0;
    ex_store_data = '0;
    if (stage_q.valid) begin
      SrcA          = fwd_a;
      SrcB          = stage_q.alu_src ? stage_q.imm : fwd_b;
      ex_store_data = fwd_b;
    end
  end

  assign Operation     = stage_q.alu_op;
  assign ex_valid      = stage_q.valid;
  assign ex_pc         = stage_q.pc;
  assign ex_rd         = stage_q.rd;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_mem_to_reg = stage_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the EX slot.
// Follows the ID_EX_FORWARDING_EN macro in the same way as the design.
module tb_id_ex_stage;

  localparam int VW = 1 + 32 + 5 + 4 + 4 + 96;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [3:0]  id_alu_op = '0;
  logic        id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic        id_mem_write = 1'b0, id_mem_to_reg = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [31:0] exmem_result = '0, memwb_result = '0;

  logic [31:0] SrcA, SrcB, ex_pc, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        load_use_hazard;

  int errors = 0;
  int checks = 0;

  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .exmem_rd(exmem_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {ex_valid, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
                    ex_mem_write, ex_mem_to_reg, Operation, SrcA, SrcB,
                    ex_store_data};

  // Model of the instruction occupying EX.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src, rw, mr, mw, m2r;
  } slot_t;

  slot_t m;

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.pc = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.op = 0;
    s.src = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0;
    return s;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_EX_FORWARDING_EN
    if (idx != 0 && exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
`endif
    return rf;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [31:0] a, b, s;
    a = 0; b = 0; s = 0;
    if (m.valid) begin
      a = fwd(m.rs1, m.rs1d);
      s = fwd(m.rs2, m.rs2d);
      b = m.src ? m.imm : s;
    end
    return {m.valid, m.pc, m.rd, m.rw, m.mr, m.mw, m.m2r, m.op, a, b, s};
  endfunction

  function automatic logic exp_hazard();
    logic [4:0] srcs [2];
    logic h;
    if (!reset || !id_valid) return 1'b0;
    srcs[0] = id_rs1; srcs[1] = id_rs2;
    h = 1'b0;
    foreach (srcs[i]) begin
`ifdef ID_EX_FORWARDING_EN
      if (m.valid && m.mr && m.rd != 0 && m.rd == srcs[i]) h = 1'b1;
`else
      if (srcs[i] != 0 &&
          ((m.valid && m.rw && m.rd == srcs[i]) ||
           (exmem_reg_write && exmem_rd == srcs[i]))) h = 1'b1;
`endif
    end
    return h;
  endfunction

  // Advance one clock edge, updating the model from the inputs at the edge.
  task automatic tick();
    slot_t nxt;
    nxt = m;
    if (!reset || flush) nxt = empty_slot();
    else if (stall) nxt = m;
    else if (exp_hazard()) nxt = empty_slot();
    else begin
      nxt.valid = id_valid; nxt.pc = id_pc; nxt.rs1d = id_rs1_data;
      nxt.rs2d = id_rs2_data; nxt.imm = id_imm; nxt.rs1 = id_rs1;
      nxt.rs2 = id_rs2; nxt.rd = id_rd; nxt.op = id_alu_op;
      nxt.src = id_alu_src; nxt.rw = id_reg_write; nxt.mr = id_mem_read;
      nxt.mw = id_mem_write; nxt.m2r = id_mem_to_reg;
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic rand_id();
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_alu_op = 4'($urandom); id_alu_src = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
  endtask

  task automatic fwd_off();
    exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_result = 0; memwb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2);
    id_valid = 1; id_pc = 32'h0000_1000; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = 32'h0000_0004;
    id_alu_op = 4'b0010; id_alu_src = 0; id_reg_write = 1;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      exmem_rd = 5'($urandom); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      stall = 1'($urandom); flush = 1'($urandom);
      tick();
    end
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", ex_valid);
    end
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL reset_hazard: got %b expected 0", load_use_hazard);
    end
    stall = 0; flush = 0; fwd_off(); id_valid = 0;
    reset = 1;
    tick();
  endtask

  task automatic test_forwarding();
    fwd_off(); stall = 0; flush = 0;
    set_id(5'd5, 5'd6, 5'd8, 32'h0000_AAAA, 32'h0000_BBBB);
    tick();
    checks++;
    if (Operation !== 4'b0010 || SrcA !== 32'h0000_AAAA) begin
      errors++; $display("FAIL fwd_capture: got op=%h a=%h expected op=2 a=0000aaaa", Operation, SrcA);
    end
    stall = 1; id_valid = 0;
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h22;
    #1;
    checks++;
`ifdef ID_EX_FORWARDING_EN
    if (SrcA !== 32'h11) begin
      errors++; $display("FAIL fwd_exmem_wins: got %h expected 00000011", SrcA);
    end
`else
    if (SrcA !== 32'h0000_AAAA) begin
      errors++; $display("FAIL fwd_disabled_a: got %h expected 0000aaaa", SrcA);
    end
`endif
    exmem_reg_write = 0;
    #1;
    checks++;
`ifdef ID_EX_FORWARDING_EN
    if (SrcA !== 32'h22) begin
      errors++; $display("FAIL fwd_memwb: got %h expected 00000022", SrcA);
    end
`else
    if (SrcA !== 32'h0000_AAAA) begin
      errors++; $display("FAIL fwd_disabled_a2: got %h expected 0000aaaa", SrcA);
    end
`endif
    stall = 0;
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'h99;
    memwb_rd = 0; memwb_reg_write = 1; memwb_result = 32'h88;
    set_id(5'd0, 5'd6, 5'd9, 32'h77, 32'h66);
    tick();
    checks++;
    if (SrcA !== 32'h77 || SrcB !== 32'h66) begin
      errors++; $display("FAIL fwd_x0: got a=%h b=%h expected a=00000077 b=00000066", SrcA, SrcB);
    end
  endtask

  task automatic test_imm();
    fwd_off(); stall = 0;
    set_id(5'd1, 5'd6, 5'd10, 32'h1, 32'h1234);
    id_alu_src = 1; id_imm = 32'hFFFF_FFF0;
    tick();
    stall = 1; id_valid = 0;
    exmem_rd = 6; exmem_reg_write = 1; exmem_result = 32'h33;
    #1;
    checks++;
    if (SrcB !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL imm_srcb: got %h expected fffffff0", SrcB);
    end
    checks++;
`ifdef ID_EX_FORWARDING_EN
    if (ex_store_data !== 32'h33) begin
      errors++; $display("FAIL imm_store: got %h expected 00000033", ex_store_data);
    end
`else
    if (ex_store_data !== 32'h1234) begin
      errors++; $display("FAIL imm_store: got %h expected 00001234", ex_store_data);
    end
`endif
    stall = 0; fwd_off();
  endtask

  task automatic test_load_use();
    fwd_off(); stall = 0;
    set_id(5'd1, 5'd2, 5'd7, 32'h5, 32'h6);
    id_mem_read = 1; id_mem_to_reg = 1;
    tick();
    set_id(5'd3, 5'd7, 5'd12, 32'h0, 32'h0);
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL lu_hazard: got %b expected 1", load_use_hazard);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 ||
        {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, Operation} !== '0) begin
      errors++; $display("FAIL lu_bubble: got v=%b ctl=%b%b%b%b op=%h expected all 0",
                         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, Operation);
    end
    set_id(5'd1, 5'd2, 5'd7, 32'h5, 32'h6);
    tick();
    set_id(5'd3, 5'd7, 5'd12, 32'h0, 32'h0);
    #1;
    checks++;
`ifdef ID_EX_FORWARDING_EN
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL lu_nonload: got %b expected 0", load_use_hazard);
    end
`else
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL raw_nonload: got %b expected 1", load_use_hazard);
    end
`endif
    id_rs1 = 0; id_rs2 = 0;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL lu_rs0: got %b expected 0", load_use_hazard);
    end
    id_valid = 0;
    tick();
  endtask

  task automatic test_stall_flush();
    logic [VW-1:0] held;
    fwd_off(); stall = 0; flush = 0;
    set_id(5'd1, 5'd2, 5'd11, 32'hCAFE_0001, 32'hCAFE_0002);
    id_pc = 32'h0000_2040; id_alu_op = 4'b0110; id_mem_write = 1;
    tick();
    held = exp_vec();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      checks++;
      if (dut_vec !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, dut_vec, held);
      end
    end
    flush = 1;
    tick();
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL stall_flush_bubble: got %h expected 0", dut_vec);
    end
    stall = 0; flush = 0; id_valid = 0;
  endtask

`ifndef ID_EX_FORWARDING_EN
  task automatic test_raw_interlock();
    fwd_off(); stall = 0; flush = 0;
    set_id(5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    tick();
    set_id(5'd3, 5'd0, 5'd4, 32'h0, 32'h0);
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL raw_ex: got %b expected 1", load_use_hazard);
    end
    tick();
    exmem_rd = 3; exmem_reg_write = 1;
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL raw_exmem: got %b expected 1", load_use_hazard);
    end
    tick();
    exmem_reg_write = 0; exmem_rd = 0; memwb_rd = 3; memwb_reg_write = 1;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL raw_memwb: got %b expected 0", load_use_hazard);
    end
    tick();
    fwd_off(); id_valid = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom);
      exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom);
      memwb_result = $urandom;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 31) != 0);
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_outputs[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (load_use_hazard !== exp_hazard()) begin
        errors++; $display("FAIL rand_hazard[%0d]: got %b expected %b", i, load_use_hazard, exp_hazard());
      end
      tick();
    end
    reset = 1; stall = 0; flush = 0;
  endtask

  initial begin
    m = empty_slot();
    test_reset();
    test_forwarding();
    test_imm();
    test_load_use();
    test_stall_flush();
`ifndef ID_EX_FORWARDING_EN
    test_raw_interlock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
